// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RISC-V subset control FSM
// Enables are gated by reset so that nothing fires while reset is held low.
module multicycle_controller #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic [3:0] state,
    output logic       retire,
    output logic       halted
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        LUI      = 4'd11,
        ILLEGAL  = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    state_t state_q, state_d;
    logic   pcw, irw, mw, rw, ret, hlt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_R:              state_d = EXECR;
                    OP_I:              state_d = EXECI;
                    OP_BEQ:            state_d = BEQ;
                    OP_JAL:            state_d = JAL;
                    OP_LUI:            state_d = LUI;
                    default:           state_d = ILLEGAL;
                endcase
            end
            MEMADR:   state_d = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD:  if (mem_ready) state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: if (mem_ready) state_d = FETCH;
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BEQ:      state_d = FETCH;
            JAL:      state_d = ALUWB;
            LUI:      state_d = FETCH;
            ILLEGAL:  if (!HALT_ON_ILLEGAL) state_d = FETCH;
            default:  state_d = ILLEGAL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        pcw        = 1'b0;
        irw        = 1'b0;
        mw         = 1'b0;
        rw         = 1'b0;
        ret        = 1'b0;
        hlt        = 1'b0;
        adr_src    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (state_q)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pcw        = mem_ready;
                irw        = mem_ready;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = 2'b01;
                rw         = 1'b1;
                ret        = 1'b1;
            end
            MEMWRITE: begin
                adr_src = 1'b1;
                mw      = 1'b1;
                ret     = mem_ready;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            ALUWB: begin
                rw  = 1'b1;
                ret = 1'b1;
            end
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pcw       = zero;
                ret       = 1'b1;
            end
            // The link value old PC + 4 is formed here and written in ALUWB.
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pcw       = 1'b1;
            end
            LUI: begin
                result_src = 2'b11;
                rw         = 1'b1;
                ret        = 1'b1;
            end
            ILLEGAL:  hlt = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_STORE: imm_src = 3'b001;
            OP_BEQ:   imm_src = 3'b010;
            OP_JAL:   imm_src = 3'b011;
            OP_LUI:   imm_src = 3'b100;
            default:  imm_src = 3'b000;
        endcase
    end

    assign pc_write  = reset & pcw;
    assign ir_write  = reset & irw;
    assign mem_write = reset & mw;
    assign reg_write = reset & rw;
    assign retire    = reset & ret;
    assign halted    = reset & hlt;
    assign state     = state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - random instruction-level check of multicycle_controller
module tb_multicycle_controller;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] LU  = 7'b0110111;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       pc_write, adr_src, ir_write, mem_write, reg_write, retire, halted;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0] imm_src;
    logic [3:0] state;

    logic       nh_pc_write, nh_adr_src, nh_ir_write, nh_mem_write, nh_reg_write, nh_retire, nh_halted;
    logic [1:0] nh_result_src, nh_alu_src_a, nh_alu_src_b, nh_alu_op;
    logic [2:0] nh_imm_src;
    logic [3:0] nh_state;

    multicycle_controller u_dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write), .mem_write(mem_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src), .state(state),
        .retire(retire), .halted(halted)
    );

    multicycle_controller #(.HALT_ON_ILLEGAL(1'b0)) u_nohalt (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(nh_pc_write), .adr_src(nh_adr_src), .ir_write(nh_ir_write),
        .mem_write(nh_mem_write), .reg_write(nh_reg_write), .result_src(nh_result_src),
        .alu_src_a(nh_alu_src_a), .alu_src_b(nh_alu_src_b), .alu_op(nh_alu_op),
        .imm_src(nh_imm_src), .state(nh_state), .retire(nh_retire), .halted(nh_halted)
    );

    always #5 clk = ~clk;

    // One expected cycle: mr 0/1 forces mem_ready, 2 = random; pcw 2 = follows zero.
    typedef struct {
        int st; int mr; logic adr; logic [1:0] asa; logic [1:0] asb; logic [1:0] aop;
        logic [1:0] rs; int pcw; logic irw; logic mw; logic rw; logic ret; logic hlt;
    } step_t;

    step_t q[$];
    int    checks = 0;
    int    failures = 0;
    int    zero_mode = -1;
    int    r;

    wire logic [21:0] obs_vec = {state, pc_write, ir_write, mem_write, reg_write, retire, halted,
                                 adr_src, alu_src_a, alu_src_b, alu_op, result_src, imm_src};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_imm(input logic [6:0] op);
        case (op)
            SW:      return 3'b001;
            BQ:      return 3'b010;
            JL:      return 3'b011;
            LU:      return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    task automatic push(input int st, input int mr, input logic adr, input logic [1:0] asa,
                        input logic [1:0] asb, input logic [1:0] aop, input logic [1:0] rs,
                        input int pcw, input logic irw, input logic mw, input logic rw,
                        input logic ret, input logic hlt);
        step_t s;
        s.st = st; s.mr = mr; s.adr = adr; s.asa = asa; s.asb = asb; s.aop = aop; s.rs = rs;
        s.pcw = pcw; s.irw = irw; s.mw = mw; s.rw = rw; s.ret = ret; s.hlt = hlt;
        q.push_back(s);
    endtask

    task automatic p_fetch(input int w);
        repeat (w) push(0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0);
        push(0, 1, 0, 2'b00, 2'b10, 2'b00, 2'b10, 1, 1, 0, 0, 0, 0);
        push(1, 2, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic p_aluwb();
        push(8, 2, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 1, 0);
    endtask

    task automatic run_steps(input logic [6:0] op, output int rets);
        rets = 0;
        foreach (q[i]) begin
            step_t s;
            logic  exp_pcw;
            s = q[i];
            mem_ready = (s.mr == 2) ? 1'($urandom_range(0, 1)) : (s.mr == 1);
            zero      = (zero_mode < 0) ? 1'($urandom_range(0, 1)) : (zero_mode == 1);
            opcode    = (s.st == 1 || s.st == 2) ? op : 7'($urandom);
            @(negedge clk);
            exp_pcw = (s.pcw == 2) ? zero : (s.pcw == 1);
            check($sformatf("step_st%0d", s.st), 32'(obs_vec),
                  32'({4'(s.st), exp_pcw, s.irw, s.mw, s.rw, s.ret, s.hlt, s.adr,
                       s.asa, s.asb, s.aop, s.rs, exp_imm(opcode)}));
            rets += int'(retire);
            @(posedge clk); #1;
        end
        q.delete();
    endtask

    // kind: 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal, 6 lui
    task automatic run_instr(input int kind, input int wf, input int wm);
        logic [6:0] op;
        int         rets;
        p_fetch(wf);
        case (kind)
            0: begin
                op = LW;
                push(2, 2, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
                repeat (wm) push(3, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
                push(3, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
                push(4, 2, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0, 1, 1, 0);
            end
            1: begin
                op = SW;
                push(2, 2, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
                repeat (wm) push(5, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0);
                push(5, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 1, 0);
            end
            2: begin
                op = RT;
                push(6, 2, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0);
                p_aluwb();
            end
            3: begin
                op = IT;
                push(7, 2, 0, 2'b10, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0);
                p_aluwb();
            end
            4: begin
                op = BQ;
                push(9, 2, 0, 2'b10, 2'b00, 2'b01, 2'b00, 2, 0, 0, 0, 1, 0);
            end
            5: begin
                op = JL;
                push(10, 2, 0, 2'b01, 2'b10, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0);
                p_aluwb();
            end
            default: begin
                op = LU;
                push(11, 2, 0, 2'b00, 2'b00, 2'b00, 2'b11, 0, 0, 0, 1, 1, 0);
            end
        endcase
        run_steps(op, rets);
        check($sformatf("retire_once_k%0d", kind), 32'(rets), 32'd1);
    endtask

    initial begin
        reset = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = LW;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(state), 32'd0);
        check("reset_enables", 32'({pc_write, ir_write, mem_write, reg_write, retire, halted}), 32'd0);
        check("reset_state_nh", 32'(nh_state), 32'd0);
        reset = 1'b1;

        run_instr(0, 0, 0);
        run_instr(1, 0, 2);
        zero_mode = 1; run_instr(4, 0, 0);
        zero_mode = 0; run_instr(4, 0, 0);
        zero_mode = -1;
        run_instr(5, 0, 0);
        run_instr(6, 0, 0);
        for (int n = 0; n < 150; n++)
            run_instr($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3));

        // Reset pulsed mid-way through a load's memory wait
        p_fetch(0);
        push(2, 2, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        push(3, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        run_steps(LW, r);
        mem_ready = 1'b0;
        check("memread_before_rst", 32'(state), 32'd3);
        #2 reset = 1'b0;
        #1 check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_regw", 32'(reg_write), 32'd0);
        mem_ready = 1'b1;
        #1 check("async_rst_enables", 32'({pc_write, ir_write, mem_write, reg_write, retire, halted}), 32'd0);
        @(posedge clk); #3 reset = 1'b1;
        run_instr(0, 1, 1);

        // Reset aborting a store while mem_write is held
        p_fetch(0);
        push(2, 2, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        push(5, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0);
        run_steps(SW, r);
        mem_ready = 1'b0;
        check("sw_wait_mw", 32'(mem_write), 32'd1);
        #1 reset = 1'b0;
        #1 check("sw_abort_mw", 32'(mem_write), 32'd0);
        check("sw_abort_state", 32'(state), 32'd0);
        @(posedge clk); #3 reset = 1'b1;
        run_instr(1, 0, 1);

        // Illegal opcode: halting instance parks, non-halting instance skips
        p_fetch(1);
        run_steps(7'b0000000, r);
        for (int i = 0; i < 10; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            opcode    = 7'($urandom);
            @(negedge clk);
            check("ill_state", 32'(state), 32'd12);
            check("ill_out", 32'({pc_write, ir_write, mem_write, reg_write, retire, halted}), 32'd1);
            if (i == 0) check("nh_ill", 32'({nh_state, nh_halted}), 32'({4'd12, 1'b1}));
            if (i == 1) check("nh_fetch", 32'({nh_state, nh_halted}), 32'({4'd0, 1'b0}));
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1 check("ill_cleared", 32'({state, halted}), 32'd0);
        @(posedge clk); #3 reset = 1'b1;
        run_instr(3, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
